// File: rtl/md_pkg.sv
// Shared types and constants for the M-extension multiply/divide controller.
package md_pkg;

    localparam int unsigned MD_ITER    = 32;
    localparam int unsigned MD_CNT_W   = 6;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_iter_dp.sv
// One-bit-per-cycle multiply/divide datapath on operand magnitudes, with
// sign correction and word selection applied combinationally on the result.
module md_iter_dp
    import md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load_i,
    input  logic            step_i,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned RW = XLEN + 1;

    logic [AW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    md_op_t          op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;

    logic            a_signed, b_signed;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] sub_low;
    logic            borrow;
    logic [AW-1:0]   prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        mag_a    = (a_signed && a_i[XLEN-1]) ? (~a_i + XLEN'(1)) : a_i;
        mag_b    = (b_signed && b_i[XLEN-1]) ? (~b_i + XLEN'(1)) : b_i;
    end

    // Remainder register holds {partial remainder, next dividend bit}; it is
    // always below twice the divisor, so the low word of the difference is exact.
    always_comb begin
        mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : RW'(0));
        borrow  = rem_q < {1'b0, opnd_q};
        sub_low = rem_q[XLEN-1:0] - opnd_q;
    end

    always_comb begin
        acc_d   = acc_q;
        rem_d   = rem_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        if (load_i) begin
            op_d    = op_i;
            neg_a_d = a_signed && a_i[XLEN-1];
            neg_b_d = b_signed && b_i[XLEN-1];
            if (op_i[2]) begin
                opnd_d = mag_b;
                acc_d  = {XLEN'(0), mag_a[XLEN-2:0], 1'b0};
                rem_d  = {XLEN'(0), mag_a[XLEN-1]};
            end else begin
                opnd_d = mag_a;
                acc_d  = {XLEN'(0), mag_b};
                rem_d  = RW'(0);
            end
        end else if (step_i) begin
            if (op_q[2]) begin
                rem_d = {(borrow ? rem_q[XLEN-1:0] : sub_low), acc_q[XLEN-1]};
                acc_d = {acc_q[AW-1:XLEN], acc_q[XLEN-2:0], ~borrow};
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + AW'(1)) : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? (~rem_q[XLEN:1] + XLEN'(1)) : rem_q[XLEN:1];
        unique case (op_q)
            OP_MUL:                       result_c = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_c = prod_fix[AW-1:XLEN];
            OP_DIV, OP_DIVU:              result_c = quo_fix;
            default:                      result_c = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            rem_q   <= '0;
            opnd_q  <= '0;
            op_q    <= OP_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage M-extension controller: FSM, iteration counter, special-case
// short-cuts and pipeline stall generation around the iterative datapath.
module ex_muldiv_ctrl
    import md_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            md_start_E,
    input  logic [2:0]      md_op_E,
    input  logic [XLEN-1:0] md_a_E,
    input  logic [XLEN-1:0] md_b_E,
    input  logic            flush_E,
    output logic            stall_E,
    output logic            md_busy,
    output logic            md_done_E,
    output logic [XLEN-1:0] md_result_E
);

    md_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]     md_result_q, md_result_d;

    md_op_t          op_e;
    logic            b_zero, ovf, special;
    logic [XLEN-1:0] spec_res;
    logic            dp_load, dp_step;
    logic [XLEN-1:0] dp_result;

    md_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (dp_load),
        .step_i   (dp_step),
        .op_i     (op_e),
        .a_i      (md_a_E),
        .b_i      (md_b_E),
        .result_c (dp_result)
    );

    // Divide-by-zero and signed overflow finish in one cycle with fixed results.
    always_comb begin
        op_e    = md_op_t'(md_op_E);
        b_zero  = (md_b_E == '0);
        ovf     = ((op_e == OP_DIV) || (op_e == OP_REM)) &&
                  (md_a_E == XLEN'(INT_MIN)) && (md_b_E == '1);
        special = md_op_E[2] && (b_zero || ovf);
        if (b_zero) begin
            spec_res = ((op_e == OP_DIV) || (op_e == OP_DIVU)) ? XLEN'(DIV_ZERO_Q) : md_a_E;
        end else begin
            spec_res = (op_e == OP_DIV) ? XLEN'(INT_MIN) : XLEN'(0);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_result_d = md_result_q;
        dp_load     = 1'b0;
        dp_step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md_start_E && !flush_E) begin
                    if (special) begin
                        md_result_d = spec_res;
                        state_d     = DONE;
                    end else begin
                        dp_load = 1'b1;
                        cnt_d   = MD_CNT_W'(MD_ITER);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!flush_E) begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q - MD_CNT_W'(1);
                    if (cnt_q == MD_CNT_W'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (!flush_E) begin
                    md_result_d = dp_result;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_E) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_result_q <= md_result_d;
        end
    end

    // Stall is gated by reset so the pipeline sees it low while reset is held.
    assign stall_E     = reset_n && (((state_q == IDLE) && md_start_E && !flush_E) ||
                                     (state_q == CALC) || (state_q == FIX));
    assign md_busy     = (state_q == CALC) || (state_q == FIX);
    assign md_done_E   = (state_q == DONE);
    assign md_result_E = md_result_q;

endmodule
